wb_seq_ctrl: RTL and testbench
==============================

Name: wb_seq_ctrl

Overview:
- Writeback sequencer for the 16-bit processor.
- Accepts one instruction at a time from decode and drives the writeback mux select (0 = ALU result, 1 = memory data).
- For loads, runs the memory read request/acknowledge handshake and captures the returned data, so the mux memory input is stable during writeback.
- Issues the register-file write strobe, stalls decode while busy, and flags a memory timeout fault.

Parameters:
DATA_W, 16, width of memory read data and captured data
RADDR_W, 3, register-file address width
MEM_TIMEOUT, 15, max cycles in MEM without ack before fault; 0 disables timeout

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
instr_valid  input  1  decode presents an instruction
instr_ready  output  1  block can accept; high only in IDLE
is_load  input  1  instruction result comes from memory
wr_req  input  1  instruction writes the register file
rd_addr  input  RADDR_W  destination register
mem_rd_req  output  1  memory read request, level, held until ack
mem_rd_ack  input  1  memory read data valid
mem_rdata  input  DATA_W  memory read data
mem_data_q  output  DATA_W  captured load data, to mux memory input
alu_out_select  output  1  writeback mux select, 1 = memory data
rf_we  output  1  register-file write enable, one-cycle pulse
rf_waddr  output  RADDR_W  register-file write address
stall  output  1  equals NOT instr_ready
mem_fault  output  1  sticky timeout fault
fault_clr  input  1  clears mem_fault and returns to IDLE

Behaviour:
- States: IDLE, MEM, WB, FAULT.
- Reset (async, rst_n low), in any state including mid-handshake:
  - state = IDLE.
  - All outputs 0: mem_rd_req, rf_we, alu_out_select, mem_fault, mem_data_q, rf_waddr, timeout counter.
  - instr_ready = 1, stall = 0.
- IDLE:
  - instr_ready = 1.
  - On instr_valid: latch is_load into sel_q, wr_req into we_q, and rd_addr into rf_waddr.
  - Next state: MEM if is_load, else WB.
  - instr_valid low: stay in IDLE.
- MEM:
  - mem_rd_req = 1, counter increments each cycle.
  - On mem_rd_ack sampled high: mem_data_q <= mem_rdata, next state WB.
  - An ack in the first MEM cycle is legal (zero-wait memory).
  - If MEM_TIMEOUT != 0, counter reaches MEM_TIMEOUT, and ack is low that cycle: next state FAULT.
  - Ack and the timeout boundary in the same cycle: the ack wins.
- WB (exactly one cycle):
  - alu_out_select = sel_q; rf_we = we_q.
  - Next state IDLE, counter cleared.
- FAULT:
  - mem_fault = 1, mem_rd_req = 0, rf_we never asserted, instr_ready = 0.
  - On fault_clr: mem_fault <= 0, next state IDLE.
  - fault_clr in any other state is ignored.
- Output hold rules:
  - alu_out_select holds its last value outside WB, so the mux output is stable for later debug reads.
  - mem_data_q holds until the next ack.
- Latency, with acceptance in cycle N:
  - ALU op: rf_we in N+1.
  - Load with ack in cycle N+1+k (k >= 0): rf_we in N+2+k.
- Throughput: accepts at most one instruction per 2 cycles. Back-to-back ALU ops accept in N and N+2.
- An instruction with wr_req = 0 still traverses WB; rf_we stays 0.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

Decomposition:
- Package wb_seq_pkg holds:
  - State enum (IDLE=2'd0, MEM=2'd1, WB=2'd2, FAULT=2'd3).
  - Constant SEL_ALU = 1'b0, SEL_MEM = 1'b1.
  - Timeout counter width function (clog2 of MEM_TIMEOUT+1).
- No sub-module; the timeout counter stays inline.

Test Plan:
- ALU op: instr_valid=1, is_load=0, wr_req=1, rd_addr=5 in cycle 0 -> rf_we=1, rf_waddr=5, alu_out_select=0 in cycle 1; instr_ready=1 in cycle 2.
- Load, ack after 3 cycles with mem_rdata=16'hBEEF:
  - mem_rd_req high cycles 1-4.
  - mem_data_q=16'hBEEF from cycle 5.
  - rf_we=1 and alu_out_select=1 in cycle 5.
- Zero-wait load: ack high in the first MEM cycle -> mem_rd_req high one cycle, rf_we the next cycle.
- Timeout, MEM_TIMEOUT=15, no ack:
  - mem_fault=1 after 16 MEM cycles; rf_we never pulses; stall=1.
  - fault_clr -> instr_ready=1 the next cycle.
- Reset mid-MEM: rst_n low during wait -> mem_rd_req, rf_we and stall drop immediately (asynchronously); after release, state IDLE and a new ALU op completes normally.
- Load with wr_req=0 -> handshake completes, mem_data_q updated, rf_we stays 0.

Source files
------------

// File: rtl/wb_seq_pkg.sv
// Shared types and constants for the writeback sequencer.
package wb_seq_pkg;

  // Sequencer states; encoding is fixed so debug probes read stable values.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEM   = 2'd1,
    WB    = 2'd2,
    FAULT = 2'd3
  } state_t;

  // Writeback mux select values.
  localparam logic SEL_ALU = 1'b0;
  localparam logic SEL_MEM = 1'b1;

  // Width needed to count up to the timeout value; never less than one bit,
  // so a disabled timeout (0) still yields a legal vector.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_seq_ctrl.sv
// Writeback sequencer: accepts one instruction at a time, runs the memory
// read handshake for loads, then issues a single-cycle register-file write.
// Every output is a register or a pure decode of the state register.
module wb_seq_ctrl
  import wb_seq_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int RADDR_W     = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               is_load,
  input  logic               wr_req,
  input  logic [RADDR_W-1:0] rd_addr,
  output logic               mem_rd_req,
  input  logic               mem_rd_ack,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [DATA_W-1:0]  mem_data_q,
  output logic               alu_out_select,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic               stall,
  output logic               mem_fault,
  input  logic               fault_clr
);

  localparam int               CNT_W       = cnt_width(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);
  localparam logic             TIMEOUT_EN  = (MEM_TIMEOUT != 0);

  state_t             state_reg, state_next;
  logic               sel_q, we_q;
  logic [CNT_W-1:0]   cnt_reg;
  logic               alu_sel_reg;
  logic [DATA_W-1:0]  data_reg;
  logic [RADDR_W-1:0] waddr_reg;
  logic               accept;
  logic               timed_out;

  assign accept    = (state_reg == IDLE) && instr_valid;
  // An ack at the boundary cycle takes priority because it is checked first below.
  assign timed_out = TIMEOUT_EN && (cnt_reg == TIMEOUT_VAL);

  // Next-state decode; ack is tested before the timeout so it wins a tie.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (instr_valid) state_next = is_load ? MEM : WB;
      MEM: begin
        if (mem_rd_ack)     state_next = WB;
        else if (timed_out) state_next = FAULT;
      end
      WB:      state_next = IDLE;
      FAULT:   if (fault_clr) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Latch the instruction attributes at acceptance; they are not resampled later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= SEL_ALU;
      we_q      <= 1'b0;
      waddr_reg <= '0;
    end else if (accept) begin
      sel_q     <= is_load;
      we_q      <= wr_req;
      waddr_reg <= rd_addr;
    end
  end

  // Wait counter: counts MEM cycles, held at zero everywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt_reg <= '0;
    else if (state_reg == MEM)  cnt_reg <= cnt_reg + CNT_W'(1);
    else                        cnt_reg <= '0;
  end

  // Capture load data on ack; held until the next ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               data_reg <= '0;
    else if (state_reg == MEM && mem_rd_ack)  data_reg <= mem_rdata;
  end

  // Mux select is loaded on entry to WB and then held for later debug reads.
  // From IDLE the fresh is_load is used because sel_q updates on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 alu_sel_reg <= SEL_ALU;
    else if (state_next == WB)  alu_sel_reg <= (state_reg == IDLE) ? is_load : sel_q;
  end

  assign instr_ready    = (state_reg == IDLE);
  assign stall          = ~instr_ready;
  assign mem_rd_req     = (state_reg == MEM);
  assign rf_we          = (state_reg == WB) && we_q;
  assign mem_fault      = (state_reg == FAULT);
  assign rf_waddr       = waddr_reg;
  assign mem_data_q     = data_reg;
  assign alu_out_select = alu_sel_reg;

endmodule

// File: tb/tb_wb_seq_ctrl.sv
// Self-checking bench for wb_seq_ctrl with randomized transactions.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_wb_seq_ctrl;

  localparam int DATA_W      = 16;
  localparam int RADDR_W     = 3;
  localparam int MEM_TIMEOUT = 15;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               instr_valid, is_load, wr_req;
  logic [RADDR_W-1:0] rd_addr;
  logic               instr_ready, mem_rd_req, mem_rd_ack;
  logic [DATA_W-1:0]  mem_rdata, mem_data_q;
  logic               alu_out_select, rf_we, stall, mem_fault, fault_clr;
  logic [RADDR_W-1:0] rf_waddr;

  int checks   = 0;
  int failures = 0;

  // Reference state at transaction level: last captured load data and last
  // writeback select, plus last written address.
  logic [DATA_W-1:0]  exp_data;
  logic               exp_sel;
  logic [RADDR_W-1:0] exp_waddr;

  wb_seq_ctrl #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .is_load(is_load), .wr_req(wr_req), .rd_addr(rd_addr),
    .mem_rd_req(mem_rd_req), .mem_rd_ack(mem_rd_ack), .mem_rdata(mem_rdata),
    .mem_data_q(mem_data_q), .alu_out_select(alu_out_select),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .stall(stall),
    .mem_fault(mem_fault), .fault_clr(fault_clr)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    checks++;
    if ({instr_ready, stall, mem_rd_req, rf_we, alu_out_select, mem_fault} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=100000",
               {instr_ready, stall, mem_rd_req, rf_we, alu_out_select, mem_fault});
    end
    checks++;
    if ({mem_data_q, rf_waddr} !== '0) begin
      failures++;
      $display("FAIL reset_data got data=%h waddr=%0d want 0", mem_data_q, rf_waddr);
    end
    exp_data = '0; exp_sel = 1'b0; exp_waddr = '0;
  endtask

  // ALU op accepted in cycle 0: writeback in cycle 1, ready again in cycle 2.
  task automatic test_alu(input logic [RADDR_W-1:0] a, input logic wr);
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++; $display("FAIL alu_ready0 got=%b want=1", instr_ready);
    end
    instr_valid = 1'b1; is_load = 1'b0; wr_req = wr; rd_addr = a;
    @(negedge clk);
    instr_valid = 1'b0; rd_addr = ~a;
    exp_sel = 1'b0; exp_waddr = a;
    checks++;
    if ({rf_we, rf_waddr, alu_out_select, stall, mem_rd_req} !== {wr, a, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL alu_wb got we=%b waddr=%0d sel=%b stall=%b req=%b want we=%b waddr=%0d sel=0 stall=1 req=0",
               rf_we, rf_waddr, alu_out_select, stall, mem_rd_req, wr, a);
    end
    @(negedge clk);
    checks++;
    if ({instr_ready, rf_we, alu_out_select, mem_data_q} !== {1'b1, 1'b0, exp_sel, exp_data}) begin
      failures++;
      $display("FAIL alu_after got ready=%b we=%b sel=%b data=%h want ready=1 we=0 sel=%b data=%h",
               instr_ready, rf_we, alu_out_select, mem_data_q, exp_sel, exp_data);
    end
    $display("txn alu addr=%0d wr=%b", a, wr);
  endtask

  // Load accepted in cycle 0 with ack in cycle 1+k: writeback in cycle 2+k.
  task automatic test_load(input logic [RADDR_W-1:0] a, input logic wr,
                           input int k, input logic [DATA_W-1:0] d);
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++; $display("FAIL load_ready0 got=%b want=1", instr_ready);
    end
    instr_valid = 1'b1; is_load = 1'b1; wr_req = wr; rd_addr = a;
    for (int i = 0; i <= k; i++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      checks++;
      if ({mem_rd_req, rf_we, stall, mem_fault, mem_data_q} !== {4'b1010, exp_data}) begin
        failures++;
        $display("FAIL load_mem%0d got req=%b we=%b stall=%b flt=%b data=%h want req=1 we=0 stall=1 flt=0 data=%h",
                 i, mem_rd_req, rf_we, stall, mem_fault, mem_data_q, exp_data);
      end
      mem_rd_ack = (i == k);
      mem_rdata  = (i == k) ? d : DATA_W'($urandom);
    end
    @(negedge clk);
    mem_rd_ack = 1'b0; mem_rdata = DATA_W'($urandom);
    exp_data = d; exp_sel = 1'b1; exp_waddr = a;
    checks++;
    if ({rf_we, rf_waddr, alu_out_select, mem_rd_req, mem_data_q} !== {wr, a, 1'b1, 1'b0, d}) begin
      failures++;
      $display("FAIL load_wb got we=%b waddr=%0d sel=%b req=%b data=%h want we=%b waddr=%0d sel=1 req=0 data=%h",
               rf_we, rf_waddr, alu_out_select, mem_rd_req, mem_data_q, wr, a, d);
    end
    @(negedge clk);
    checks++;
    if ({instr_ready, rf_we, alu_out_select, mem_data_q} !== {1'b1, 1'b0, 1'b1, d}) begin
      failures++;
      $display("FAIL load_after got ready=%b we=%b sel=%b data=%h want ready=1 we=0 sel=1 data=%h",
               instr_ready, rf_we, alu_out_select, mem_data_q, d);
    end
    $display("txn load addr=%0d wr=%b wait=%0d data=%h", a, wr, k, d);
  endtask

  // Two ALU ops with valid held high: accepted in cycles 0 and 2.
  task automatic test_back_to_back(input logic [RADDR_W-1:0] a1, input logic [RADDR_W-1:0] a2);
    @(negedge clk);
    instr_valid = 1'b1; is_load = 1'b0; wr_req = 1'b1; rd_addr = a1;
    @(negedge clk);
    rd_addr = a2;
    checks++;
    if ({rf_we, rf_waddr, instr_ready} !== {1'b1, a1, 1'b0}) begin
      failures++;
      $display("FAIL b2b_first got we=%b waddr=%0d ready=%b want we=1 waddr=%0d ready=0",
               rf_we, rf_waddr, instr_ready, a1);
    end
    @(negedge clk);
    checks++;
    if ({instr_ready, rf_we} !== 2'b10) begin
      failures++; $display("FAIL b2b_gap got ready=%b we=%b want ready=1 we=0", instr_ready, rf_we);
    end
    @(negedge clk);
    instr_valid = 1'b0;
    exp_sel = 1'b0; exp_waddr = a2;
    checks++;
    if ({rf_we, rf_waddr} !== {1'b1, a2}) begin
      failures++;
      $display("FAIL b2b_second got we=%b waddr=%0d want we=1 waddr=%0d", rf_we, rf_waddr, a2);
    end
    @(negedge clk);
    $display("txn back_to_back addr1=%0d addr2=%0d", a1, a2);
  endtask

  // Load with no ack: fault after MEM_TIMEOUT+1 MEM cycles, cleared by fault_clr.
  task automatic test_timeout(input logic [RADDR_W-1:0] a);
    int bad_we;
    bad_we = 0;
    @(negedge clk);
    instr_valid = 1'b1; is_load = 1'b1; wr_req = 1'b1; rd_addr = a;
    for (int i = 0; i <= MEM_TIMEOUT; i++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      if (rf_we !== 1'b0) bad_we++;
      checks++;
      if ({mem_rd_req, mem_fault} !== 2'b10) begin
        failures++;
        $display("FAIL timeout_mem%0d got req=%b flt=%b want req=1 flt=0", i, mem_rd_req, mem_fault);
      end
    end
    // Decode may try to issue during the fault; it must be refused.
    instr_valid = 1'b1; is_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rf_we !== 1'b0) bad_we++;
      checks++;
      if ({mem_fault, mem_rd_req, stall, instr_ready} !== 4'b1010) begin
        failures++;
        $display("FAIL timeout_fault%0d got flt=%b req=%b stall=%b ready=%b want flt=1 req=0 stall=1 ready=0",
                 i, mem_fault, mem_rd_req, stall, instr_ready);
      end
    end
    instr_valid = 1'b0;
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    checks++;
    if ({instr_ready, mem_fault, stall, rf_we} !== 4'b1000 || bad_we != 0) begin
      failures++;
      $display("FAIL timeout_clear got ready=%b flt=%b stall=%b we=%b stray_we=%0d want ready=1 flt=0 stall=0 we=0 stray_we=0",
               instr_ready, mem_fault, stall, rf_we, bad_we);
    end
    checks++;
    if ({mem_data_q, alu_out_select} !== {exp_data, exp_sel}) begin
      failures++;
      $display("FAIL timeout_hold got data=%h sel=%b want data=%h sel=%b",
               mem_data_q, alu_out_select, exp_data, exp_sel);
    end
    $display("txn timeout addr=%0d", a);
  endtask

  // Asynchronous reset during a memory wait.
  task automatic test_reset_mid_mem();
    @(negedge clk);
    instr_valid = 1'b1; is_load = 1'b1; wr_req = 1'b1; rd_addr = 3'd6;
    repeat (3) @(negedge clk);
    instr_valid = 1'b0;
    checks++;
    if (mem_rd_req !== 1'b1) begin
      failures++; $display("FAIL rstmem_pre got req=%b want=1", mem_rd_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_rd_req, rf_we, stall, instr_ready, mem_fault, alu_out_select} !== 6'b000100
        || {mem_data_q, rf_waddr} !== '0) begin
      failures++;
      $display("FAIL rstmem_async got req=%b we=%b stall=%b ready=%b flt=%b sel=%b data=%h waddr=%0d want all 0 except ready=1",
               mem_rd_req, rf_we, stall, instr_ready, mem_fault, alu_out_select, mem_data_q, rf_waddr);
    end
    exp_data = '0; exp_sel = 1'b0; exp_waddr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn reset_mid_mem");
    test_alu(3'd2, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; is_load = 1'b0; wr_req = 1'b0; rd_addr = '0;
    mem_rd_ack = 1'b0; mem_rdata = '0; fault_clr = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    // fault_clr outside FAULT must have no effect.
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    test_alu(3'd5, 1'b1);
    test_load(3'd3, 1'b1, 3, 16'hBEEF);
    test_load(3'd1, 1'b1, 0, 16'h1234);
    test_load(3'd7, 1'b1, MEM_TIMEOUT, 16'hA5A5);
    test_load(3'd4, 1'b0, 2, 16'h0F0F);
    test_alu(3'd0, 1'b0);
    test_back_to_back(3'd1, 3'd6);
    test_timeout(3'd2);
    test_reset_mid_mem();
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1)
        test_load(RADDR_W'($urandom), 1'($urandom), int'($urandom_range(0, MEM_TIMEOUT)),
                  DATA_W'($urandom));
      else
        test_alu(RADDR_W'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
